// File: rtl/instruction_ram_loader_pkg.sv
// Shared definitions for instruction RAM producers and consumers:
// opcode values, 64-bit instruction field positions and loader states.
package instruction_ram_loader_pkg;

    localparam int WORD_W  = 16;
    localparam int INSTR_W = 64;

    localparam logic [15:0] OP_EOF      = 16'h0000;
    localparam logic [15:0] OP_ADD      = 16'h0001;
    localparam logic [15:0] OP_SUB      = 16'h0002;
    localparam logic [15:0] OP_MOV      = 16'h0003;
    localparam logic [15:0] OP_LOAD     = 16'h0004;
    localparam logic [15:0] OP_STORE    = 16'h0005;
    localparam logic [15:0] OP_JUMP     = 16'h0006;
    localparam logic [15:0] OP_BEQ      = 16'h0007;
    localparam logic [15:0] OP_BNE      = 16'h0008;
    localparam logic [15:0] OP_OUT      = 16'h0009;
    localparam logic [15:0] OP_IN       = 16'h000A;
    localparam logic [15:0] OP_KEYBOARD = 16'h000B;

    localparam int OPCODE_HI = 63;
    localparam int OPCODE_LO = 48;
    localparam int A_HI      = 47;
    localparam int A_LO      = 32;
    localparam int B_HI      = 31;
    localparam int B_LO      = 16;
    localparam int C_HI      = 15;
    localparam int C_LO      = 0;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_WRITE        = 3'd3,
        ST_DONE         = 3'd4
    } load_state_e;

endpackage

// File: rtl/instruction_ram_loader_press_debouncer.sv
// Turns the level word_valid into an accept pulse (while waiting for a press)
// and a released pulse after DEBOUNCE_CYCLES consecutive low samples.
module press_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic press_en,
    input  logic release_en,
    input  logic word_valid,
    output logic accept,
    output logic released
);
    import instruction_ram_loader_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign accept   = press_en & word_valid;
    // The last low sample of the run releases on the same edge it is counted.
    assign released = release_en & ~word_valid & (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (release_en && !released && !word_valid) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_ram_loader.sv
// Packs four operator-entered 16-bit words into 64-bit instructions and writes
// them to instruction RAM from address 0 until an EOF opcode or RAM full.
module instruction_ram_loader #(
    parameter int          DEPTH           = 256,
    parameter int          DEBOUNCE_CYCLES = 1000,
    parameter logic [15:0] OP_EOF          = instruction_ram_loader_pkg::OP_EOF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic [15:0] ram_address,
    output logic [63:0] ram_data,
    output logic        ram_wren,
    output logic [1:0]  word_index,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);
    import instruction_ram_loader_pkg::*;

    localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

    // Handshake: word_valid is a level with no ready. A word is taken on the
    // first high sample while waiting for a press; the next word is taken only
    // after word_valid has been low for DEBOUNCE_CYCLES consecutive cycles.

    load_state_e state_q, state_d;
    logic [15:0] ram_address_q, ram_address_d;
    logic [63:0] ram_data_q, ram_data_d;
    logic [63:0] instr_q, instr_d;
    logic [1:0]  word_index_q, word_index_d;
    logic        ram_wren_q, ram_wren_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept, released;

    press_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_press_debouncer (
        .clock     (clock),
        .reset_n   (reset_n),
        .press_en  (state_q == ST_WAIT_PRESS),
        .release_en(state_q == ST_WAIT_RELEASE),
        .word_valid(word_valid),
        .accept    (accept),
        .released  (released)
    );

    always_comb begin
        state_d       = state_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        instr_d       = instr_q;
        word_index_d  = word_index_q;
        error_d       = error_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_WAIT_PRESS;
                    ram_address_d = '0;
                    word_index_d  = '0;
                    error_d       = 1'b0;
                end
            end
            ST_WAIT_PRESS: begin
                if (accept) begin
                    case (word_index_q)
                        2'd0:    instr_d[OPCODE_HI:OPCODE_LO] = word_in;
                        2'd1:    instr_d[A_HI:A_LO]           = word_in;
                        2'd2:    instr_d[B_HI:B_LO]           = word_in;
                        default: instr_d[C_HI:C_LO]           = word_in;
                    endcase
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (released) begin
                    if (word_index_q == 2'd3) begin
                        // Latch the whole instruction so ram_data is stable during the strobe.
                        ram_data_d = instr_q;
                        state_d    = ST_WRITE;
                    end else begin
                        word_index_d = word_index_q + 2'd1;
                        state_d      = ST_WAIT_PRESS;
                    end
                end
            end
            ST_WRITE: begin
                word_index_d = '0;
                if (ram_data_q[OPCODE_HI:OPCODE_LO] == OP_EOF) begin
                    state_d = ST_DONE;
                end else if (ram_address_q == LAST_ADDR) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ram_address_d = ram_address_q + 16'd1;
                    state_d       = ST_WAIT_PRESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ram_wren_d = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            instr_q       <= '0;
            word_index_q  <= '0;
            ram_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            instr_q       <= instr_d;
            word_index_q  <= word_index_d;
            ram_wren_q    <= ram_wren_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign word_index  = word_index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/instruction_ram_loader.md
Name: instruction_ram_loader

Overview:
- Write-side counterpart to the CPU's instruction fetch path. The fetch path only reads instruction RAM; this block fills it.
- Collects 16-bit words from a level-valid source (switches plus push-button) and packs every four words into one 64-bit instruction {opcode, a, b, c}.
- Writes each instruction into instruction RAM at consecutive addresses from 0, and stops after writing the OP_EOF instruction.
- Top level muxes the RAM address/data/wren between this block and the fetch path using busy; the CPU stays idle while busy=1.

Parameters:
- DEPTH, 256, number of 64-bit instruction RAM words; addresses 0..DEPTH-1.
- DEBOUNCE_CYCLES, 1000, consecutive cycles word_valid must be low before the next word is accepted; minimum 1.
- OP_EOF, 16'd0, opcode value that terminates loading.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from address 0.
- word_in  in  16  word to capture (switch value).
- word_valid  in  1  level; high means the operator is presenting word_in (button pressed).
- ram_address  out  16  instruction RAM write address.
- ram_data  out  64  instruction to write; bits 63:48 = word 0 (opcode), then a, b, c.
- ram_wren  out  1  one-cycle write strobe.
- word_index  out  2  slot of the next word to be captured (0..3); intended for LEDs.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- error  out  1  high in DONE when RAM filled without an EOF.

Behaviour:
- Reset, sampled only on a clock edge:
  - state=IDLE; ram_address=0, ram_data=0, ram_wren=0, word_index=0, busy=0, done=0, error=0; debounce counter=0.
  - Reset mid-load abandons the partially assembled instruction. RAM contents already written are untouched.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, WRITE, DONE.
- IDLE:
  - start=1 moves to WAIT_PRESS next cycle, clearing ram_address, word_index, error and the debounce counter.
  - All other inputs are ignored.
- WAIT_PRESS:
  - word_valid=1 latches word_in into the slot selected by word_index (slot 0 = bits 63:48) and moves to WAIT_RELEASE.
  - Capture latency is 1 cycle from the word_valid sample.
- WAIT_RELEASE:
  - Debounce counter increments on each cycle with word_valid=0 and clears to 0 on any cycle with word_valid=1.
  - When the counter reaches DEBOUNCE_CYCLES: clear the counter.
    - If word_index==3, go to WRITE.
    - Otherwise increment word_index and go to WAIT_PRESS.
  - A held button therefore captures exactly one word. Bounce shorter than DEBOUNCE_CYCLES never double-captures.
- WRITE (exactly 1 cycle):
  - ram_wren=1 with the current ram_address and the assembled ram_data.
  - On the next cycle ram_wren=0 and word_index=0.
  - If ram_data[63:48]==OP_EOF, go to DONE with error=0; ram_address keeps the EOF address.
  - Else if ram_address==DEPTH-1, go to DONE with error=1 (RAM full, no EOF).
  - Else increment ram_address and go to WAIT_PRESS.
- DONE:
  - done=1 and busy=0; error holds its value.
  - start=1 restarts exactly as from IDLE; otherwise remain in DONE.
- start is ignored while busy=1.
- ram_address never exceeds DEPTH-1 and never wraps.
- ram_data holds its last value outside WRITE and must not change while ram_wren=1.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds opcode constants (OP_EOF..OP_KEYBOARD, 16-bit) and instruction field positions (OPCODE 63:48, A 47:32, B 31:16, C 15:0). The CPU and this loader both import it.
- One sub-module, press_debouncer: converts word_valid into a single-cycle "accept" pulse and a "released" pulse gated by DEBOUNCE_CYCLES.
- The FSM, word packing and address counter stay in the top.

Test Plan:
- Basic load (DEBOUNCE_CYCLES=4): start, then present words 0x0003,0x0005,0x0002,0x0000 followed by 0x0000 ×4 → one ram_wren at address 0 with data 0x0003_0005_0002_0000, one at address 1 with opcode 0, then done=1, error=0, ram_address=1.
- Held/bouncy button: word_valid high for 50 cycles, then three low-for-2-cycle glitches, then low for 4 cycles → exactly one word captured; word_index goes 0→1 only after the final 4-cycle low run.
- Overflow (DEPTH=4): four non-EOF instructions (opcode 0x0006) → writes at addresses 0..3, then done=1, error=1, ram_address=3; no fifth write.
- Reset mid-load: after two words captured, pulse reset_n=0 for one cycle → state IDLE, word_index=0, busy=0, no ram_wren; a fresh start writes from address 0.
- Restart and ignored start: start asserted while busy → no effect; after DONE, start → done=0, busy=1, ram_address=0, next write lands at 0.
- Word order check: words 0x000B,0x1234,0xABCD,0xFFFF → ram_data=0x000B_1234_ABCD_FFFF on the write cycle; ram_data stable throughout the ram_wren cycle.
